// File: rtl/mult_pkg.sv
// Shared types and constants for the multiplier sequencer (mult_ctrl / mult_wdt).
package mult_pkg;

  localparam int unsigned MULT_WIDTH       = 32;
  localparam int unsigned MULT_WDT_DEFAULT = 40;

  // Enough bits to hold 0..cycles inclusive.
  function automatic int unsigned wdt_cnt_width(input int unsigned cycles);
    return $clog2(cycles + 1);
  endfunction

  localparam int unsigned MULT_WDT_CNT_W = $clog2(MULT_WDT_DEFAULT + 1);

  typedef enum logic {
    StIdle,
    StRun
  } mult_state_e;

endpackage

// File: rtl/mult_wdt.sv
// Watchdog for a multiplier run: counts RUN cycles and flags expiry on the
// Cycles-th RUN cycle so the sequencer can leave RUN at that edge.
module mult_wdt
  import mult_pkg::*;
#(
  parameter int unsigned Cycles = MULT_WDT_DEFAULT
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic run_i,
  output logic expire_o
);

  localparam int unsigned CntW = wdt_cnt_width(Cycles);

  logic [CntW-1:0] cnt_q;

  // Cleared on acceptance, counts every RUN cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (run_i) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // cnt_q holds the number of completed RUN cycles, so Cycles-1 marks the last one.
  assign expire_o = run_i && (cnt_q == CntW'(Cycles - 1));

endmodule

// File: rtl/mult_ctrl.sv
// Execute-stage sequencer for the iterative multiplier: latches operands,
// grants the shared ALU, stalls the pipe while running and owns HI/LO.
// Optional watchdog enabled by defining MULT_WDT_EN.
module mult_ctrl
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH      = MULT_WIDTH,
  parameter int unsigned WDT_CYCLES = MULT_WDT_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mult_req,
  input  logic             mult_sgn,
  input  logic             flush,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             mf_sel,
  input  logic             mult_done,
  input  logic [WIDTH-1:0] mult_hi,
  input  logic [WIDTH-1:0] mult_lo,
  output logic             mult_start,
  output logic             mult_sgn_o,
  output logic [WIDTH-1:0] op_a,
  output logic [WIDTH-1:0] op_b,
  output logic             alu_grant,
  output logic             stall,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] mf_data,
  output logic             wdt_err
);

  mult_state_e      state_q;
  logic [WIDTH-1:0] op_a_q, op_b_q, hi_q, lo_q;
  logic             sgn_q;
  logic             accept;
  logic             running;
  logic             wdt_expire;

  assign running = (state_q == StRun);
  assign accept  = (state_q == StIdle) && mult_req && !flush;

`ifdef MULT_WDT_EN
  logic wdt_err_q;

  mult_wdt #(
    .Cycles (WDT_CYCLES)
  ) u_wdt (
    .clk_i    (clk),
    .rst_ni   (rst),
    .clr_i    (accept),
    .run_i    (running),
    .expire_o (wdt_expire)
  );

  assign wdt_err = wdt_err_q;
`else
  logic unused_wdt_cycles;
  assign unused_wdt_cycles = ^WDT_CYCLES;
  assign wdt_expire        = 1'b0;
  assign wdt_err           = 1'b0;
`endif

  // FSM plus operand and HI/LO registers; reset discards any partial product.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      op_a_q    <= '0;
      op_b_q    <= '0;
      sgn_q     <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
`ifdef MULT_WDT_EN
      wdt_err_q <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            op_a_q  <= src_a;
            op_b_q  <= src_b;
            sgn_q   <= mult_sgn;
            state_q <= StRun;
          end
        end
        StRun: begin
          // Completion wins over a coincident watchdog expiry.
          if (mult_done) begin
            hi_q    <= mult_hi;
            lo_q    <= mult_lo;
            state_q <= StIdle;
          end else if (wdt_expire) begin
            state_q   <= StIdle;
`ifdef MULT_WDT_EN
            wdt_err_q <= 1'b1;
`endif
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign mult_start = running;
  assign alu_grant  = running;
  assign stall      = running;
  assign busy       = running;
  assign mult_sgn_o = sgn_q;
  assign op_a       = op_a_q;
  assign op_b       = op_b_q;
  assign hi         = hi_q;
  assign lo         = lo_q;
  // No bypass: reads behind a running mult are held off by stall.
  assign mf_data    = mf_sel ? hi_q : lo_q;

endmodule

// File: tb/tb_mult_ctrl.sv
// Scoreboard bench for mult_ctrl with a behavioural multiplier model.
module tb_mult_ctrl;

  localparam int unsigned W   = 32;
  localparam int unsigned WDT = 40;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         mult_req = 1'b0, mult_sgn = 1'b0, flush = 1'b0, mf_sel = 1'b0;
  logic [W-1:0] src_a = '0, src_b = '0;
  logic         mult_done = 1'b0;
  logic [W-1:0] mult_hi = '0, mult_lo = '0;
  logic         mult_start, mult_sgn_o, alu_grant, stall, busy, wdt_err;
  logic [W-1:0] op_a, op_b, hi, lo, mf_data;

  always #5 clk = ~clk;

  mult_ctrl #(
    .WIDTH      (W),
    .WDT_CYCLES (WDT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .mult_req   (mult_req),
    .mult_sgn   (mult_sgn),
    .flush      (flush),
    .src_a      (src_a),
    .src_b      (src_b),
    .mf_sel     (mf_sel),
    .mult_done  (mult_done),
    .mult_hi    (mult_hi),
    .mult_lo    (mult_lo),
    .mult_start (mult_start),
    .mult_sgn_o (mult_sgn_o),
    .op_a       (op_a),
    .op_b       (op_b),
    .alu_grant  (alu_grant),
    .stall      (stall),
    .busy       (busy),
    .hi         (hi),
    .lo         (lo),
    .mf_data    (mf_data),
    .wdt_err    (wdt_err)
  );

  // kind: 0 = normal completion, 1 = aborted by reset, 2 = watchdog expiry
  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sgn;
    int           lat;
    int           kind;
    logic [W-1:0] eh;
    logic [W-1:0] el;
  } exp_t;

  exp_t         sb[$];
  int           lat_q[$];
  int           total = 0;
  int           bad = 0;
  logic [W-1:0] arch_hi = '0, arch_lo = '0;
  logic         stray_done = 1'b0;

  function automatic logic [63:0] prod(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic sgn);
    logic signed [63:0] sa, sbv;
    logic [63:0] ua, ub;
    sa  = $signed(a);
    sbv = $signed(b);
    ua  = {32'b0, a};
    ub  = {32'b0, b};
    if (sgn) return sa * sbv;
    return ua * ub;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Multiplier model: pulses done on the lat-th RUN cycle (lat 0 = never).
  initial begin
    int n = 0;
    int cur_lat = 0;
    logic [63:0] p;
    forever begin
      @(negedge clk);
      #1;
      if (busy) begin
        if (n == 0) cur_lat = (lat_q.size() != 0) ? lat_q.pop_front() : 0;
        n++;
        if (n == cur_lat) begin
          p         = prod(op_a, op_b, mult_sgn_o);
          mult_done = 1'b1;
          mult_hi   = p[63:32];
          mult_lo   = p[31:0];
        end else begin
          mult_done = 1'b0;
          mult_hi   = $urandom;
          mult_lo   = $urandom;
        end
      end else begin
        n         = 0;
        mult_done = stray_done;
        mult_hi   = $urandom;
        mult_lo   = $urandom;
      end
    end
  end

  // Monitor: checks RUN outputs each cycle and pops the scoreboard when busy falls.
  initial begin
    logic pb = 1'b0;
    int   sc = 0;
    logic wdt_sticky = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (busy) begin
        sc++;
        if (sb.size() == 0) begin
          chk("run_without_issue", 64'(busy), 64'(0));
        end else begin
          chk("run_op_a", 64'(op_a), 64'(sb[0].a));
          chk("run_op_b", 64'(op_b), 64'(sb[0].b));
          chk("run_sgn", 64'(mult_sgn_o), 64'(sb[0].sgn));
          chk("run_ctl", {61'b0, stall, alu_grant, mult_start}, 64'd7);
        end
      end else if (pb) begin
        if (sb.size() == 0) begin
          chk("done_without_issue", 64'(sb.size()), 64'(1));
        end else begin
          e = sb.pop_front();
          chk("hi", 64'(hi), 64'(e.eh));
          chk("lo", 64'(lo), 64'(e.el));
          chk("mf_data", 64'(mf_data), 64'(mf_sel ? e.eh : e.el));
          chk("idle_ctl", {61'b0, stall, alu_grant, mult_start}, 64'd0);
          if (e.kind != 1) chk("stall_cycles", 64'(sc), 64'(e.lat));
          if (e.kind == 2) wdt_sticky = 1'b1;
          if (e.kind == 1) wdt_sticky = 1'b0;
          chk("wdt_err", 64'(wdt_err), 64'(wdt_sticky));
        end
        sc = 0;
      end
      pb = busy;
    end
  end

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn,
                       input int lat, input int kind);
    int   g = 0;
    exp_t e;
    logic [63:0] p;
    @(negedge clk);
    mult_req = 1'b1;
    flush    = 1'b0;
    src_a    = a;
    src_b    = b;
    mult_sgn = sgn;
    mf_sel   = 1'($urandom);
    while (busy && g < 300) begin
      @(negedge clk);
      g++;
    end
    if (busy) begin
      chk("issue_timeout", 64'(busy), 64'(0));
      mult_req = 1'b0;
      return;
    end
    p = prod(a, b, sgn);
    if (kind == 0) begin
      arch_hi = p[63:32];
      arch_lo = p[31:0];
    end else if (kind == 1) begin
      arch_hi = '0;
      arch_lo = '0;
    end
    e.a = a; e.b = b; e.sgn = sgn; e.kind = kind;
    e.lat = (kind == 2) ? int'(WDT) : lat;
    e.eh = arch_hi; e.el = arch_lo;
    sb.push_back(e);
    lat_q.push_back(lat);
    @(posedge clk);
    #1;
    chk("accept", 64'(busy), 64'(1));
    // Scramble inputs during RUN; the operand registers must stay frozen.
    mult_req = 1'b0;
    src_a    = $urandom;
    src_b    = $urandom;
    mult_sgn = 1'($urandom);
    flush    = 1'($urandom);
  endtask

  task automatic wait_idle();
    int g = 0;
    while ((busy || sb.size() != 0) && g < 500) begin
      @(negedge clk);
      g++;
    end
    if (busy || sb.size() != 0) chk("idle_timeout", 64'(sb.size()), 64'(0));
    flush = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state before any clock edge.
    #2;
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_ctl", {61'b0, stall, alu_grant, mult_start}, 64'd0);
    chk("rst_hilo", {hi, lo}, 64'd0);
    chk("rst_ops", {op_a, op_b}, 64'd0);
    chk("rst_sgn_wdt", {62'b0, mult_sgn_o, wdt_err}, 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    issue(32'd7, 32'd6, 1'b1, 32, 0);
    wait_idle();
    mf_sel = 1'b0;
    #1 chk("mflo_7x6", 64'(mf_data), 64'h2A);
    issue(32'hFFFF_FFFD, 32'd5, 1'b1, 7, 0);
    wait_idle();

    // Flushed request is ignored.
    mult_req = 1'b1; flush = 1'b1; src_a = $urandom; src_b = $urandom;
    @(negedge clk);
    chk("flush_idle", {62'b0, busy, stall}, 64'd0);
    @(negedge clk);
    chk("flush_hilo", {hi, lo}, {arch_hi, arch_lo});
    mult_req = 1'b0; flush = 1'b0;

    // Stray done in IDLE must not update HI/LO.
    stray_done = 1'b1;
    @(negedge clk);
    stray_done = 1'b0;
    @(negedge clk);
    chk("stray_hilo", {hi, lo}, {arch_hi, arch_lo});
    chk("stray_busy", 64'(busy), 64'(0));

    // Back-to-back; the second request is held during the first RUN.
    issue(32'hFFFF_FFFF, 32'd2, 1'b0, 5, 0);
    issue(32'd3, 32'd3, 1'b0, 4, 0);
    wait_idle();

    // Reset mid-RUN clears everything without a clock edge.
    issue(32'd3, 32'd3, 1'b0, 0, 1);
    repeat (3) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk("arst_ctl", {60'b0, busy, stall, alu_grant, mult_start}, 64'd0);
    chk("arst_hilo", {hi, lo}, 64'd0);
    chk("arst_ops", {op_a, op_b}, 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    wait_idle();

    // Randomised operations, sometimes back-to-back.
    for (int i = 0; i < 12; i++) begin
      issue($urandom, $urandom, 1'($urandom), int'($urandom_range(1, 32)), 0);
      if ($urandom_range(0, 1) == 0) wait_idle();
    end
    wait_idle();

`ifdef MULT_WDT_EN
    issue($urandom, $urandom, 1'($urandom), 0, 2);
    wait_idle();
    repeat (3) @(negedge clk);
    chk("wdt_sticky", 64'(wdt_err), 64'(1));
    issue(32'd5, 32'd5, 1'b0, 3, 0);
    wait_idle();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
